// File: rtl/bg_pattern_gen_pkg.sv
// Shared constants and config types for the background pattern generator.
// Pattern mode encodings match the SPI register block's background_state field.
package bg_pkg;

    localparam int COLOR_W = 6;
    localparam int MODE_W  = 8;
    localparam int CFG_W   = MODE_W + COLOR_W;

    localparam logic [MODE_W-1:0] BG_SOLID   = 8'd0;
    localparam logic [MODE_W-1:0] BG_HGRAD   = 8'd1;
    localparam logic [MODE_W-1:0] BG_VBARS   = 8'd2;
    localparam logic [MODE_W-1:0] BG_CHECKER = 8'd3;
    localparam logic [MODE_W-1:0] BG_DIAG    = 8'd4;
    localparam logic [MODE_W-1:0] BG_PLASMA  = 8'd10;

    localparam logic [MODE_W-1:0] BG_RESET_MODE = BG_PLASMA;

    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [COLOR_W-1:0] color;
    } bg_cfg_t;

    localparam bg_cfg_t BG_CFG_RESET = '{mode: BG_RESET_MODE, color: '0};

endpackage

// File: rtl/bg_pattern_gen_cfg_sync.sv
// Multi-flop synchronizer for a quasi-static config bus, with an optional
// stability filter enabled by the BG_STABLE_FILTER_EN macro.
module cfg_sync #(
    parameter int               WIDTH         = 14,
    parameter int               SYNC_STAGES   = 2,
    parameter int               STABLE_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_async,
    output logic [WIDTH-1:0] accepted
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
        end
    end

`ifdef BG_STABLE_FILTER_EN
    localparam int               CNT_W   = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sample_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        cnt_next = '0;
        if (sync_last == sample_q) begin
            cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        end
    end

    // A multi-bit skewed transition never survives STABLE_CYCLES equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            cnt_q    <= '0;
            accepted <= RESET_VAL;
        end else begin
            sample_q <= sync_last;
            cnt_q    <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                accepted <= sample_q;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            accepted <= RESET_VAL;
        end else begin
            accepted <= sync_last;
        end
    end
`endif

endmodule

// File: rtl/bg_pattern_gen.sv
// Pixel-domain background generator: syncs SCLK-domain config, commits it at
// frame_start, and emits a registered 6-bit RGB pixel. Optional macro: BG_STABLE_FILTER_EN.
module bg_pattern_gen
    import bg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FRAME_DIV     = 1,
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bg_state_async,
    input  logic [5:0] solid_color_async,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       frame_start,
    output logic [5:0] rgb,
    output logic [7:0] mode_active,
    output logic [7:0] frame_cnt
);

    bg_cfg_t            acc_cfg;
    logic [COLOR_W-1:0] color_q;
    logic [7:0]         presc_q;
    logic [5:0]         diag_pix;
    logic [5:0]         pix;

    cfg_sync #(
        .WIDTH        (CFG_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .RESET_VAL    (BG_CFG_RESET)
    ) u_cfg_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async ({bg_state_async, solid_color_async}),
        .accepted(acc_cfg)
    );

    // Config and animation only move at frame boundaries, never mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_active <= BG_RESET_MODE;
            color_q     <= '0;
            frame_cnt   <= '0;
            presc_q     <= '0;
        end else if (frame_start) begin
            mode_active <= acc_cfg.mode;
            color_q     <= acc_cfg.color;
            if (presc_q == 8'(FRAME_DIV - 1)) begin
                presc_q   <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                presc_q <= presc_q + 8'd1;
            end
        end
    end

    assign diag_pix = 6'((hpos + vpos + {2'b00, frame_cnt}) >> 4);

    always_comb begin
        pix = '0;
        case (mode_active)
            BG_SOLID:   pix = color_q;
            BG_HGRAD:   pix = hpos[8:3];
            BG_VBARS:   pix = {hpos[8:6], ~hpos[8:6]};
            BG_CHECKER: pix = (hpos[5] ^ vpos[5]) ? color_q : ~color_q;
            BG_DIAG:    pix = diag_pix;
            BG_PLASMA:  pix = (hpos[7:2] ^ vpos[7:2]) + frame_cnt[5:0];
            default:    pix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
        end else begin
            rgb <= display_on ? pix : 6'd0;
        end
    end

endmodule

// File: doc/bg_pattern_gen.md
Name: bg_pattern_gen

Overview:
- Pixel-clock-domain consumer of the SPI register block's configuration outputs.
- Safely brings `background_state` and `solid_color` across from the SCLK domain, then commits them at frame boundaries.
- Generates a registered 6-bit RGB background pixel from the current beam position and a frame-based animation counter.
- Feeds the VGA output mux; sprites and other overlays sit downstream.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth per bit (minimum 2).
- FRAME_DIV, 1: frames per animation step; `frame_cnt` advances once every FRAME_DIV `frame_start` pulses (1..255).
- STABLE_CYCLES, 2: consecutive identical synchronized samples required before a value is accepted.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- bg_state_async  in  8  `background_state` from the SCLK domain
- solid_color_async  in  6  `solid_color` from the SCLK domain
- hpos  in  10  current pixel column
- vpos  in  10  current pixel row
- display_on  in  1  active-video flag for hpos/vpos
- frame_start  in  1  one-cycle strobe at start of vertical blank
- rgb  out  6  {R[1:0],G[1:0],B[1:0]}, registered
- mode_active  out  8  currently committed background mode
- frame_cnt  out  8  animation counter

Behaviour:
- Reset values:
  - rgb=0, mode_active=10 (BG_PLASMA), committed color=0, frame_cnt=0, prescaler=0.
  - Synchronizer flops, filter sample and filter counter clear to 0.
  - Accepted value clears to {mode 10, color 0}.
- Synchronizer:
  - Both buses are concatenated into 14 bits and passed through SYNC_STAGES flops.
  - Stability filter: counter increments while the last sync stage equals its previous sample, and resets to 0 on any difference.
  - When the counter reaches STABLE_CYCLES-1 the sample is copied to the accepted register; the counter saturates there.
- Commit:
  - On a `frame_start` cycle, mode_active and the committed color load from the accepted register as it stood before that edge.
  - A value accepted in the same cycle as `frame_start` waits for the next `frame_start`.
  - No change occurs mid-frame.
- Animation:
  - On `frame_start`, prescaler increments.
  - When prescaler==FRAME_DIV-1, prescaler returns to 0 and frame_cnt increments, wrapping 255->0.
  - Commit and frame_cnt update land on the same edge; both take effect for pixels from the next cycle onward.
- Patterns use mode_active and committed color S:
  - 0 SOLID: S
  - 1 HGRAD: hpos[8:3]
  - 2 VBARS: {hpos[8:6], ~hpos[8:6]}
  - 3 CHECKER: (hpos[5]^vpos[5]) ? S : ~S
  - 4 DIAG: sum=(hpos+vpos+frame_cnt) mod 1024, rgb=sum[9:4]
  - 10 PLASMA: ((hpos[7:2]^vpos[7:2]) + frame_cnt[5:0]) mod 64
  - any other value: 0
- Output timing:
  - Latency is exactly 1 cycle: rgb at edge N+1 reflects hpos/vpos/display_on sampled at edge N.
  - rgb=0 whenever the sampled display_on=0.
- Reset mid-frame: rgb=0 on the next cycle; all state returns to reset values regardless of frame_start or display_on.
- All arithmetic is unsigned and truncates; there are no overflow flags.

Optional Feature:
- Macro: `BG_STABLE_FILTER_EN`.
- Defined: the stability filter operates as described; accepted-value latency is SYNC_STAGES+STABLE_CYCLES cycles.
- Undefined: the filter is removed; the accepted register copies the last sync stage every cycle, with latency SYNC_STAGES+1. STABLE_CYCLES is ignored.
- Commit-on-frame_start is unchanged in both builds.

Decomposition:
- Package bg_pkg holds:
  - Mode constants: BG_SOLID=0, BG_HGRAD=1, BG_VBARS=2, BG_CHECKER=3, BG_DIAG=4, BG_PLASMA=10.
  - BG_RESET_MODE=BG_PLASMA, COLOR_W=6, MODE_W=8.
- One sub-module, cfg_sync: a parameterized width/stages synchronizer plus stability filter (filter under the macro), producing the accepted value.
- Pattern selection and commit logic stay in bg_pattern_gen.

Test Plan:
- Reset then frame_start with inputs 0 → mode_active=10 immediately after reset. After commit, mode_active=0; with hpos=0,vpos=0,display_on=1, rgb=0x00 one cycle later.
- bg_state_async=0, solid_color_async=6'h2D, wait 6 cycles, pulse frame_start → mode_active=0; rgb=0x2D on every active pixel and 0x00 when display_on=0.
- mode 3, S=6'h0F: hpos=32,vpos=0 → rgb=0x0F; hpos=32,vpos=32 → rgb=0x30; rgb is always 1 cycle after input.
- mode 10, FRAME_DIV=1, three frame_start pulses: hpos=4,vpos=0 → rgb=(1^0)+3=0x04; after 256 pulses frame_cnt wraps to 0.
- bg_state_async toggles 1→2→1 on alternate cycles, then settles at 4 (filter on) → accepted register does not take 2 during toggling; mode_active changes only at the next frame_start after stability. Change arriving mid-frame → rgb pattern unchanged until frame_start.
- Assert rst mid-line with mode 4 active → next cycle rgb=0, mode_active=10, frame_cnt=0.
